// File: rtl/bmm_operand_loader.sv
// Operand loader for the Barrett modular multiplier: assembles A, B, M and mu from a word stream.
// Latency: op_valid rises one cycle after the final word of a frame is accepted.
// Backpressure: in_ready drops while an operand set is held in ISSUE, until op_ready consumes it.
module bmm_operand_loader #(
  parameter int N = 256,
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic           in_reuse,
  output logic           in_ready,
  output logic [N-1:0]   A_out,
  output logic [N-1:0]   B_out,
  output logic [N-1:0]   M_out,
  output logic [2*N-1:0] mu_out,
  output logic           op_valid,
  input  logic           op_ready,
  output logic           key_valid,
  output logic           err
);

  // Words per N-bit field and per 2N-bit mu field.
  localparam int FW = N / W;
  localparam int MW = 2 * FW;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;

  localparam logic [CW-1:0] LAST_F  = CW'(FW - 1);
  localparam logic [CW-1:0] LAST_MU = CW'(MW - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_M,
    LOAD_MU,
    ISSUE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Goes high on the first clock edge after reset release; gates in_ready so it
  // stays low throughout reset even though the FSM already sits in LOAD_A.
  logic          live;

  // Frame type captured on the first word: 1 = A/B-only frame reusing the stored key.
  logic          reuse_q;

  logic          accept;
  logic          first_word;
  logic          reuse_now;
  logic          field_last;
  logic          frame_final;
  logic          len_err;

  assign in_ready = live && (state != ISSUE);
  assign op_valid = (state == ISSUE);
  assign accept   = in_valid && in_ready;

  // Frame bookkeeping: which word this is and whether in_last is where it belongs.
  always_comb begin
    first_word  = 1'b0;
    reuse_now   = reuse_q;
    field_last  = 1'b0;
    frame_final = 1'b0;
    len_err     = 1'b0;

    first_word = (state == LOAD_A) && (cnt == '0);
    // A reuse request only counts when a complete key is actually on hand.
    if (first_word) begin
      reuse_now = in_reuse && key_valid;
    end

    if (state == LOAD_MU) begin
      field_last = (cnt == LAST_MU);
    end else begin
      field_last = (cnt == LAST_F);
    end

    frame_final = ((state == LOAD_B) && field_last && reuse_now) ||
                  ((state == LOAD_MU) && field_last);

    len_err = accept && (in_last != frame_final);
  end

  // Next-state and word-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;

    case (state)
      LOAD_A, LOAD_B, LOAD_M, LOAD_MU: begin
        if (accept) begin
          if (len_err) begin
            // Malformed frame: drop it and wait for a fresh first word.
            state_nxt = LOAD_A;
            cnt_nxt   = '0;
          end else if (field_last) begin
            cnt_nxt = '0;
            case (state)
              LOAD_A:  state_nxt = LOAD_B;
              LOAD_B:  state_nxt = reuse_now ? ISSUE : LOAD_M;
              LOAD_M:  state_nxt = LOAD_MU;
              default: state_nxt = ISSUE;
            endcase
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (op_ready) begin
          state_nxt = LOAD_A;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = LOAD_A;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and word counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD_A;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Ready gate released on the first edge out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // Latch the frame type on the first accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reuse_q <= 1'b0;
    end else if (accept && first_word) begin
      reuse_q <= in_reuse && key_valid;
    end
  end

  // Length-error pulse, one cycle after the offending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= len_err;
    end
  end

  // Key validity: set when a full frame completes, cleared when a full frame is malformed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
    end else if (accept) begin
      if (len_err) begin
        if (!reuse_now) begin
          key_valid <= 1'b0;
        end
      end else if ((state == LOAD_MU) && field_last) begin
        key_valid <= 1'b1;
      end
    end
  end

  // Operand A: word k lands in bits [kW+W-1:kW].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A_out <= '0;
    end else if (accept && (state == LOAD_A)) begin
      for (int k = 0; k < FW; k++) begin
        if (cnt == CW'(k)) begin
          A_out[k*W +: W] <= in_data;
        end
      end
    end
  end

  // Operand B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      B_out <= '0;
    end else if (accept && (state == LOAD_B)) begin
      for (int k = 0; k < FW; k++) begin
        if (cnt == CW'(k)) begin
          B_out[k*W +: W] <= in_data;
        end
      end
    end
  end

  // Modulus M; untouched by reuse frames since they never enter LOAD_M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_out <= '0;
    end else if (accept && (state == LOAD_M)) begin
      for (int k = 0; k < FW; k++) begin
        if (cnt == CW'(k)) begin
          M_out[k*W +: W] <= in_data;
        end
      end
    end
  end

  // Barrett constant mu, twice the operand width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mu_out <= '0;
    end else if (accept && (state == LOAD_MU)) begin
      for (int k = 0; k < MW; k++) begin
        if (cnt == CW'(k)) begin
          mu_out[k*W +: W] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmm_operand_loader.sv
// Self-checking bench for bmm_operand_loader with a frame-level reference model.
module tb_bmm_operand_loader;

  localparam int N     = 256;
  localparam int W     = 64;
  localparam int FW    = N / W;
  localparam int MW    = 2 * FW;
  localparam int FRAME = 3 * FW + MW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_reuse = 1'b0;
  logic           in_ready;
  logic [N-1:0]   A_out;
  logic [N-1:0]   B_out;
  logic [N-1:0]   M_out;
  logic [2*N-1:0] mu_out;
  logic           op_valid;
  logic           op_ready = 1'b0;
  logic           key_valid;
  logic           err;

  bmm_operand_loader #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_reuse  (in_reuse),
    .in_ready  (in_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .M_out     (M_out),
    .mu_out    (mu_out),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .key_valid (key_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: last issued operands, the stored key, and its validity.
  logic [W-1:0] a_m  [FW];
  logic [W-1:0] b_m  [FW];
  logic [W-1:0] m_m  [FW];
  logic [W-1:0] mu_m [MW];
  bit           kv_m;
  logic [W-1:0] fw   [FRAME];

  task automatic chk(input string tag, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < FW; k++) begin
      a_m[k] = '0; b_m[k] = '0; m_m[k] = '0;
    end
    for (int k = 0; k < MW; k++) mu_m[k] = '0;
    kv_m = 1'b0;
  endtask

  task automatic check_ops(input string ctx);
    logic [N-1:0]   ea, eb, em;
    logic [2*N-1:0] emu;
    for (int k = 0; k < FW; k++) begin
      ea[k*W +: W] = a_m[k];
      eb[k*W +: W] = b_m[k];
      em[k*W +: W] = m_m[k];
    end
    for (int k = 0; k < MW; k++) emu[k*W +: W] = mu_m[k];
    chk({ctx, ".A"}, A_out, ea);
    chk({ctx, ".B"}, B_out, eb);
    chk({ctx, ".M"}, M_out, em);
    chk({ctx, ".mu"}, mu_out, emu);
    chk({ctx, ".key_valid"}, key_valid, kv_m);
  endtask

  task automatic check_zero(input string ctx);
    chk({ctx, ".in_ready"}, in_ready, 0);
    chk({ctx, ".op_valid"}, op_valid, 0);
    chk({ctx, ".err"}, err, 0);
    chk({ctx, ".key_valid"}, key_valid, 0);
    chk({ctx, ".A"}, A_out, 0);
    chk({ctx, ".B"}, B_out, 0);
    chk({ctx, ".M"}, M_out, 0);
    chk({ctx, ".mu"}, mu_out, 0);
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic drive_word(input logic [W-1:0] d, input bit last, input bit reuse, input int gapmax);
    repeat ($urandom_range(0, gapmax)) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom);
      in_reuse = 1'($urandom);
      @(posedge clk); #1;
    end
    in_data  = d;
    in_last  = last;
    in_reuse = reuse;
    in_valid = 1'b1;
    chk("in_ready_word", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // err_pos < 0: well-formed frame. Otherwise in_last is placed only at err_pos
  // (err_pos >= expected length means in_last is never driven).
  task automatic run_frame(input bit reuse_req, input int err_pos, input int hold, input int gapmax);
    bit full, is_err;
    int len, stop;
    full = !(reuse_req && kv_m);
    len  = full ? FRAME : 2 * FW;
    if (err_pos < 0) begin
      is_err = 1'b0;
      stop   = len - 1;
    end else begin
      is_err = 1'b1;
      stop   = (err_pos < len - 1) ? err_pos : len - 1;
    end
    for (int i = 0; i <= stop; i++) begin
      bit l;
      l = (err_pos < 0) ? (i == len - 1) : (i == err_pos);
      drive_word(fw[i], l, (i == 0) ? reuse_req : 1'($urandom), gapmax);
    end
    if (is_err) begin
      if (full) kv_m = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_no_op_valid", op_valid, 0);
      @(posedge clk); #1;
      chk("err_one_cycle", err, 0);
      chk("err_no_op_valid_later", op_valid, 0);
      chk("err_key_valid", key_valid, kv_m);
      chk("err_in_ready", in_ready, 1);
    end else begin
      for (int k = 0; k < FW; k++) begin
        a_m[k] = fw[k];
        b_m[k] = fw[FW + k];
      end
      if (full) begin
        for (int k = 0; k < FW; k++) m_m[k] = fw[2 * FW + k];
        for (int k = 0; k < MW; k++) mu_m[k] = fw[3 * FW + k];
        kv_m = 1'b1;
      end
      chk("issue_op_valid", op_valid, 1);
      chk("issue_err", err, 0);
      chk("issue_in_ready", in_ready, 0);
      check_ops("issue");
      for (int h = 0; h < hold; h++) begin
        op_ready = 1'b0;
        in_valid = 1'($urandom);
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
        @(posedge clk); #1;
        chk("hold_op_valid", op_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        check_ops("hold");
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      op_ready = 1'b1;
      @(posedge clk); #1;
      op_ready = 1'b0;
      chk("consume_op_valid", op_valid, 0);
      chk("consume_in_ready", in_ready, 1);
      chk("consume_err", err, 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < FRAME; i++) fw[i] = {$urandom, $urandom};
  endtask

  task automatic reset_mid_frame(input int words_before);
    fill_random();
    for (int i = 0; i < words_before; i++) drive_word(fw[i], 1'b0, 1'b0, 2);
    in_data  = fw[words_before];
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_zero("midreset_held");
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_err", err, 0);
    model_clear();
  endtask

  initial begin
    model_clear();

    // Reset values and in_ready release timing.
    #2;
    check_zero("reset");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Full frame of words 1..20.
    for (int i = 0; i < FRAME; i++) fw[i] = W'(i + 1);
    run_frame(1'b0, -1, 1, 0);
    chk("full_A_words", A_out, {64'd4, 64'd3, 64'd2, 64'd1});
    chk("full_key_valid", key_valid, 1);

    // Reuse frame of words 0xA..0x11: key stays from the previous frame.
    for (int i = 0; i < 2 * FW; i++) fw[i] = W'(10 + i);
    run_frame(1'b1, -1, 0, 1);
    chk("reuse_B_words", B_out, {64'h11, 64'h10, 64'hF, 64'hE});
    chk("reuse_mu_top", mu_out[2*N-1 -: W], 64'd20);

    // Downstream backpressure for 10 cycles.
    fill_random();
    run_frame(1'b0, -1, 10, 1);

    // Early in_last on the fifth word of a full frame.
    fill_random();
    run_frame(1'b0, 4, 0, 1);

    // Reuse request without a valid key: 8 words with in_last on word 8 is an error.
    fill_random();
    run_frame(1'b1, 7, 0, 1);
    fill_random();
    run_frame(1'b0, -1, 2, 2);

    // Randomized frames: mixed reuse, occasional length errors, random holds.
    for (int t = 0; t < 30; t++) begin
      bit rr;
      int ep, len;
      fill_random();
      rr  = ($urandom_range(0, 2) == 0);
      len = (rr && kv_m) ? 2 * FW : FRAME;
      ep  = -1;
      if ($urandom_range(0, 9) == 0) begin
        do ep = $urandom_range(0, len); while (ep == len - 1);
      end
      run_frame(rr, ep, $urandom_range(0, 4), 2);
    end

    // Reset during word 12, then a fresh full frame.
    reset_mid_frame(11);
    fill_random();
    run_frame(1'b0, -1, 1, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bmm_operand_loader.md
BMM_OPERAND_LOADER -- requirements
Module: bmm_operand_loader

Interface
REQ-001 SHALL have parameter N, default 256: operand width in bits, matching the Barrett multiplier it feeds.
REQ-002 SHALL have parameter W, default 64: input word width; N SHALL be an integer multiple of W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port in_data, input, W bits: operand word.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final word of a frame.
REQ-008 SHALL have port in_reuse, input, 1 bit: sampled on the first word of a frame; requests reuse of the stored M and mu.
REQ-009 SHALL have port in_ready, output, 1 bit: the loader accepts a word in this cycle.
REQ-010 SHALL have port A_out, output, N bits: assembled operand A.
REQ-011 SHALL have port B_out, output, N bits: assembled operand B.
REQ-012 SHALL have port M_out, output, N bits: assembled modulus M.
REQ-013 SHALL have port mu_out, output, 2N bits: assembled Barrett constant mu.
REQ-014 SHALL have port op_valid, output, 1 bit: operands are complete and stable.
REQ-015 SHALL have port op_ready, input, 1 bit: the downstream multiplier consumes the operand set.
REQ-016 SHALL have port key_valid, output, 1 bit: M_out and mu_out hold a complete, error-free key.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on a frame-length violation.

Function
REQ-018 A word SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-019 Full frame SHALL be 3N/W + 2N/W words in this order: A, B, M, mu, each least-significant word first.
REQ-020 Word k of a field SHALL be written to bits [kW+W-1:kW] of that field.
REQ-021 Reuse frame SHALL be 2N/W words (A then B) and SHALL apply only when in_reuse=1 on the first word and key_valid=1.
REQ-022 If in_reuse=1 and key_valid=0, the loader SHALL expect a full frame.
REQ-023 FSM states SHALL be: LOAD_A, LOAD_B, LOAD_M, LOAD_MU, ISSUE.
REQ-024 Each load state SHALL advance after its last field word is accepted: LOAD_A->LOAD_B; LOAD_B->LOAD_M on a full frame or ->ISSUE on a reuse frame; LOAD_M->LOAD_MU; LOAD_MU->ISSUE.
REQ-025 in_ready SHALL be 1 in every load state and 0 in ISSUE.
REQ-026 op_valid SHALL be 1 exactly while in ISSUE, asserting the cycle after the final word is accepted (latency 1).
REQ-027 A_out, B_out, M_out and mu_out SHALL NOT change while op_valid=1.
REQ-028 On op_valid=1 and op_ready=1, the FSM SHALL go to LOAD_A, with in_ready=1 in the following cycle.
REQ-029 op_valid SHALL remain asserted indefinitely while op_ready=0.
REQ-030 Length error (in_last=1 on a non-final accepted word, or in_last=0 on the final accepted word) SHALL pulse err for one cycle after acceptance.
REQ-031 A length error SHALL discard the frame, return the FSM to LOAD_A, and issue no op_valid.
REQ-032 A length error in a full frame SHALL clear key_valid; registers MAY hold partial data.
REQ-033 key_valid SHALL set on entry to ISSUE from LOAD_MU.
REQ-034 key_valid SHALL be unchanged on entry to ISSUE from LOAD_B via reuse.
REQ-035 The word counter SHALL wrap to 0 at each field boundary, sized ceil(log2(2N/W)) bits.
REQ-036 The loader SHALL NOT change state or registers in a cycle with in_valid=0 in a load state.

Reset
REQ-037 While reset=0 (asynchronously): FSM=LOAD_A, word counter=0, in_ready=0, op_valid=0, err=0, key_valid=0, A_out/B_out/M_out/mu_out=0.
REQ-038 in_ready SHALL rise in the first clock cycle after reset deasserts.
REQ-039 Reset asserted mid-frame or in ISSUE SHALL abandon the operation with no err pulse.

Verification
REQ-040 Full frame, N=256, W=64: 20 words with values 1..20, in_last on word 20 -> op_valid next cycle; A_out={4,3,2,1} (MS..LS words); mu_out words 13..20 in order; key_valid=1.
REQ-041 Reuse: after REQ-040, 8-word frame with in_reuse=1, words 0xA..0x11 -> op_valid after word 8; M_out and mu_out unchanged from REQ-040.
REQ-042 Backpressure: hold op_ready=0 for 10 cycles in ISSUE -> op_valid stays 1, in_ready=0, outputs stable; op_ready=1 -> in_ready=1 next cycle.
REQ-043 Early in_last on word 5 of a full frame -> err pulse of 1 cycle, key_valid=0, no op_valid; next 20-word frame processes normally.
REQ-044 Reuse request with key_valid=0 -> 8-word frame flagged err at word 8 (missing in_last is not an error there; in_last on word 8 is the violation); a 20-word frame succeeds.
REQ-045 Assert reset at word 12 with random in_valid gaps -> all outputs 0 immediately; a fresh full frame completes correctly.
